// File: rtl/ram_responder_pkg.sv
// Shared constants and address decode for the RAM responder and its I/O window.
package ram_responder_pkg;

    localparam int          ADDRESS_WIDTH = 33;
    localparam logic [31:0] IO_BASE       = 32'h30000;
    localparam logic [7:0]  IO_DATA_OFS   = 8'h00;
    localparam logic [7:0]  IO_STAT_OFS   = 8'h04;

    typedef enum logic [1:0] {
        SEL_MEM,
        SEL_IO_DATA,
        SEL_IO_STAT,
        SEL_IO_NONE
    } sel_e;

    // Only address bits [17:16] pick the I/O window; inside it only the low byte matters.
    function automatic sel_e decode_addr(input logic [1:0] region, input logic [7:0] offset);
        if (region != IO_BASE[17:16]) begin
            return SEL_MEM;
        end
        if (offset == IO_DATA_OFS) begin
            return SEL_IO_DATA;
        end
        if (offset == IO_STAT_OFS) begin
            return SEL_IO_STAT;
        end
        return SEL_IO_NONE;
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// Byte-serial RAM bus between the core's RAM controller (master) and the responder (slave).
interface ram_responder_if;
    import ram_responder_pkg::*;

    logic                     ram_rw_in;
    logic [ADDRESS_WIDTH-1:0] ram_addr_in;
    logic [7:0]               ram_data_in;
    logic [7:0]               ram_data_out;
    logic                     io_buffer_full_out;

    modport master (
        output ram_rw_in,
        output ram_addr_in,
        output ram_data_in,
        input  ram_data_out,
        input  io_buffer_full_out
    );

    modport slave (
        input  ram_rw_in,
        input  ram_addr_in,
        input  ram_data_in,
        output ram_data_out,
        output io_buffer_full_out
    );

endinterface

// File: rtl/ram_responder_byte_fifo.sv
// Byte FIFO used for the console TX and RX queues; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int DEPTH_LOG = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         din,
    output logic [7:0]         head,
    output logic               empty,
    output logic               full,
    output logic [DEPTH_LOG:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [7:0]           slots [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LOG+1)'(DEPTH));
    assign head    = slots[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Target side of the byte-serial RAM bus: main memory plus an I/O window holding
// console TX/RX FIFOs, a status register and a sticky halt flag.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH_LOG = 4,
    parameter int FULL_MARGIN    = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    ram_responder_if.slave   bus,
    output logic [7:0]       tx_data_out,
    output logic             tx_valid_out,
    input  logic             tx_ready_in,
    input  logic [7:0]       rx_data_in,
    input  logic             rx_valid_in,
    output logic             rx_ready_out,
    output logic             halt_out,
    output logic             tx_overflow_out
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam int CNT_W = FIFO_DEPTH_LOG + 1;

    logic [7:0]                mem [0:(1 << MEM_ADDR_WIDTH) - 1];
    logic [MEM_ADDR_WIDTH-1:0] idx;
    sel_e                      sel;
    logic                      is_write;
    logic                      tx_push, tx_drain, tx_empty, tx_full;
    logic                      rx_push, rx_pop, rx_empty, rx_full;
    logic [CNT_W-1:0]          tx_count, rx_count, tx_free;
    logic [7:0]                rx_head;
    logic [7:0]                read_byte;

    assign idx      = bus.ram_addr_in[MEM_ADDR_WIDTH-1:0];
    assign sel      = decode_addr(bus.ram_addr_in[17:16], bus.ram_addr_in[7:0]);
    assign is_write = bus.ram_rw_in;

    assign tx_push  = is_write && (sel == SEL_IO_DATA);
    assign tx_drain = tx_valid_out && tx_ready_in;
    assign rx_pop   = !is_write && (sel == SEL_IO_DATA);
    assign rx_push  = rx_valid_in && rx_ready_out;

    byte_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (tx_push),
        .pop   (tx_drain),
        .din   (bus.ram_data_in),
        .head  (tx_data_out),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data_in),
        .head  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    assign tx_valid_out = !tx_empty;
    assign rx_ready_out = !rx_full;

    // tx_count is a register, so the near-full flag changes on the same edge as the count.
    assign tx_free                = CNT_W'(DEPTH) - tx_count;
    assign bus.io_buffer_full_out = (tx_free < CNT_W'(FULL_MARGIN));

    always_ff @(posedge clk_in) begin
        if (is_write && (sel == SEL_MEM)) begin
            mem[idx] <= bus.ram_data_in;
        end
    end

    always_comb begin
        read_byte = 8'h00;
        case (sel)
            SEL_MEM:     read_byte = mem[idx];
            SEL_IO_DATA: read_byte = rx_empty ? 8'h00 : rx_head;
            SEL_IO_STAT: read_byte = {6'b0, tx_full, (rx_count != '0)};
            default:     read_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.ram_data_out <= 8'h00;
            halt_out         <= 1'b0;
            tx_overflow_out  <= 1'b0;
        end else begin
            if (!is_write) begin
                bus.ram_data_out <= read_byte;
            end
            if (is_write && (sel == SEL_IO_STAT)) begin
                halt_out <= 1'b1;
            end
            if (tx_push && tx_full && !tx_drain) begin
                tx_overflow_out <= 1'b1;
            end
        end
    end

endmodule
